// File: rtl/mem_access_unit_if.sv
// Load/store request and response channel between the MEM stage and mem_access_unit.
// master = requesting pipeline stage, slave = mem_access_unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the 1024x32 data memory: loads, stores, sub-word read-modify-write.
// Optional macro MAU_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mem_access_unit_if.slave bus,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [31:0]      mem_pc_o,
  input  logic [31:0]      mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  localparam logic [31:0] MemBytes = 32'(MEM_BYTES);

  state_e      state_q, state_d;
  logic        write_q, signed_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] off_q, wdata_q, pc_q, rdata_q;

  logic        accept, in_window, misalign, req_err;
  logic [31:0] req_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data, merged;

  // Offset form avoids overflow of BASE_ADDR+MEM_BYTES-1 at the top of the address space.
  assign req_off   = bus.req_addr - BASE_ADDR;
  assign in_window = (bus.req_addr >= BASE_ADDR) && (req_off < MemBytes);

`ifdef MAU_ALIGN_CHECK_EN
  assign misalign = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (bus.req_size == 2'd3) || !in_window || misalign;
  assign accept  = bus.req_valid && (state_q == StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      off_q    <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= bus.req_write;
        signed_q <= bus.req_signed;
        err_q    <= req_err;
        size_q   <= bus.req_size;
        off_q    <= req_off;
        wdata_q  <= bus.req_wdata;
        pc_q     <= bus.req_pc;
      end
      if (state_q == StRd) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d = StResp;
          end else if (bus.req_write && (bus.req_size == 2'd2)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = write_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from rdata_q.
  always_comb begin
    byte_sel = rdata_q[{off_q[1:0], 3'b000} +: 8];
    half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    ext_data = rdata_q;
    merged   = rdata_q;
    unique case (size_q)
      2'd0: begin
        ext_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
        merged[{off_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'd1: begin
        ext_data = {{16{signed_q & half_sel[15]}}, half_sel};
        if (off_q[1]) begin
          merged[31:16] = wdata_q[15:0];
        end else begin
          merged[15:0] = wdata_q[15:0];
        end
      end
      default: merged = wdata_q;
    endcase
  end

  // mem_we comes straight from the state register so reset removes it asynchronously.
  assign mem_we_o      = (state_q == StWr);
  assign mem_addr_o    = {off_q[31:2], 2'b00};
  assign mem_wdata_o   = (state_q == StWr) ? merged : '0;
  assign mem_pc_o      = pc_q;

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_err   = (state_q == StResp) && err_q;
  assign bus.rsp_rdata = ((state_q == StResp) && !err_q && !write_q) ? ext_data : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;
  localparam int unsigned MemBytes = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_clr;
  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
  logic [31:0] mem [1024];
  logic [7:0]  ref_mem [MemBytes];

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(
    .BASE_ADDR (32'h0000_0000),
    .MEM_BYTES (MemBytes)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_pc_o    (mem_pc),
    .mem_rdata_i (mem_rdata)
  );

  // Data memory: synchronous write, combinational read.
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = (size == 2'd3) || (addr >= MemBytes);
`ifdef MAU_ALIGN_CHECK_EN
    if ((size == 2'd1) && addr[0]) e = 1'b1;
    if ((size == 2'd2) && (addr[1:0] != 2'b00)) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [11:0] w;
    w = {a[11:2], 2'b00};
    return {ref_mem[w + 12'd3], ref_mem[w + 12'd2], ref_mem[w + 12'd1], ref_mem[w]};
  endfunction

  // Issue one request from a negedge with the unit idle; returns the observed rsp_rdata.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rd);
    logic [31:0] pc, exp_rd, ea;
    logic        e;
    int          n, lat, we_cnt, waited, exp_lat;
    pc     = $urandom;
    e      = exp_err(size, addr);
    n      = 1 << size;
    ea     = addr & ~32'(n - 1);
    exp_rd = '0;
    if (!e && !wr) begin
      for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_mem[ea[11:0] + 12'(i)];
      if (sgn && (n < 4) && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'd1 << (8 * n)) - 32'd1);
    end
    exp_lat = e ? 1 : ((wr && (n < 4)) ? 3 : 2);

    waited = 0;
    while (!bus.req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_pc     = pc;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat    = 1;
    we_cnt = 0;
    while (!bus.rsp_valid && lat < 8) begin
      if (mem_we) we_cnt++;
      @(negedge clk);
      lat++;
    end
    got_rd = bus.rsp_rdata;
    check_eq({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check_eq({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(e));
    check_eq({tag, " rsp_rdata"}, bus.rsp_rdata, exp_rd);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " we_cycles"}, 32'(we_cnt), (wr && !e) ? 32'd1 : 32'd0);
    check_eq({tag, " mem_pc"}, mem_pc, pc);
    check_eq({tag, " we_in_resp"}, 32'(mem_we), 32'd0);
    if (wr && !e) begin
      for (int i = 0; i < n; i++) ref_mem[ea[11:0] + 12'(i)] = wdata[8*i +: 8];
    end
    @(negedge clk);
    check_eq({tag, " pulse"}, 32'(bus.rsp_valid), 32'd0);
    if (!e) check_eq({tag, " mem_word"}, mem[ea[11:2]], ref_word(ea));
  endtask

  logic [31:0] rd;
  logic [31:0] raddr;
  logic [1:0]  rsize;
  int          waited;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_pc     = '0;
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    for (int i = 0; i < MemBytes; i++) ref_mem[i] = 8'h00;
    repeat (2) @(negedge clk);

    check_eq("rst req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    check_eq("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    check_eq("rst mem_we", 32'(mem_we), 32'd0);
    check_eq("rst mem_addr", mem_addr, 32'd0);
    check_eq("rst mem_wdata", mem_wdata, 32'd0);
    check_eq("rst mem_pc", mem_pc, 32'd0);
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    do_req("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, rd);
    do_req("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
    check_eq("lw10 const", rd, 32'h1234_5678);
    do_req("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'hAB, rd);
    check_eq("sb11 word", mem[4], 32'h1234_AB78);
    do_req("lb11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd);
    check_eq("lb11 const", rd, 32'hFFFF_FFAB);
    do_req("lbu11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd);
    check_eq("lbu11 const", rd, 32'h0000_00AB);
    do_req("sh12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h8001, rd);
    check_eq("sh12 word", mem[4], 32'h8001_AB78);
    do_req("lh12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd);
    check_eq("lh12 const", rd, 32'hFFFF_8001);
    do_req("lhu12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd);
    check_eq("lhu12 const", rd, 32'h0000_8001);
    do_req("lw13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, rd);
    do_req("sw1000", 1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEAD_BEEF, rd);
    do_req("size3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd);
    do_req("lwtop", 1'b0, 2'd2, 1'b1, 32'hFFC, 32'h0, rd);

    // Reset landing in the write cycle of a sub-word store.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h5555;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    waited = 0;
    while (!mem_we && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check_eq("abort we_seen", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort we_drop", 32'(mem_we), 32'd0);
    check_eq("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("abort word", mem[4], ref_word(32'h10));
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("abort no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check_eq("abort ready", 32'(bus.req_ready), 32'd1);

    for (int k = 0; k < 300; k++) begin
      rsize = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) raddr = 32'($urandom_range(4080, 4200));
      else if ($urandom_range(0, 19) == 0) raddr = $urandom;
      else raddr = 32'($urandom_range(0, 63));
      do_req("rand", 1'($urandom_range(0, 1)), rsize, 1'($urandom_range(0, 1)), raddr,
             $urandom, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
